alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning max cycles spent in WAIT before abort (used only when ALU_ARB_TIMEOUT_EN is defined).
REQ-002 SHALL have clk  input  1  single system clock, all state on rising edge.
REQ-003 SHALL have rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have req0, req1  input  1 each  operation request from requester 0/1.
REQ-005 SHALL have opcode0, opcode1  input  5 each  requested ALU opcode.
REQ-006 SHALL have a0, b0, a1, b1  input  8 each  operands A/B per requester.
REQ-007 SHALL have cin0, bin0, cin1, bin1  input  1 each  carry_in/borrow_in per requester.
REQ-008 SHALL have gnt0, gnt1  output  1 each  requester owns the ALU.
REQ-009 SHALL have done0, done1  output  1 each  one-cycle completion pulse.
REQ-010 SHALL have result  output  8  captured ALU result; flags  output  5  captured {overflow,negative,zero,carry_out,borrow_out}.
REQ-011 SHALL have err  output  1  one-cycle timeout pulse, coincident with done.
REQ-012 SHALL have alu_opcode 5, alu_operand_A 8, alu_operand_B 8, alu_carry_in 1, alu_borrow_in 1, alu_enable 1, alu_input_ready 1  outputs  driving the shared ALU.
REQ-013 SHALL have alu_result_out 8, alu_result_ready 1, alu_carry_out, alu_borrow_out, alu_zero, alu_negative, alu_overflow 1 each  inputs from the ALU.

Function
REQ-014 FSM states SHALL be IDLE, ISSUE, WAIT, DONE.
REQ-015 IDLE: no req -> stay; any req -> ISSUE next cycle, winner latched.
REQ-016 Arbitration SHALL be round-robin: single req wins; both asserted -> requester not equal to last_grant wins; last_grant updates on entry to ISSUE.
REQ-017 ISSUE SHALL last exactly one cycle: winner's opcode/operands/cin/bin registered onto alu_* ports, alu_input_ready=1 for that cycle only, then -> WAIT.
REQ-018 alu_* operand ports SHALL hold issued values stable from ISSUE until DONE exits.
REQ-019 alu_enable SHALL be 1 in ISSUE and WAIT, 0 otherwise.
REQ-020 WAIT: alu_result_ready=1 -> capture alu_result_out into result and flags, -> DONE; else stay.
REQ-021 DONE SHALL last one cycle: done of granted requester =1, -> IDLE.
REQ-022 gntN SHALL be 1 from ISSUE through DONE inclusive for the winner, never both high.
REQ-023 Request-to-done latency SHALL be 3 cycles plus ALU cycles in WAIT; minimum spacing between grants SHALL be 4 cycles.
REQ-024 req deasserted mid-operation SHALL NOT abort; operation completes and done still pulses.
REQ-025 req held high after done SHALL be treated as a new request in the following IDLE cycle.
REQ-026 result and flags SHALL hold last captured value until next capture.
REQ-027 alu_result_ready high in IDLE/ISSUE SHALL be ignored.

Reset
REQ-028 rst low SHALL immediately force IDLE, abandoning any in-flight operation without done.
REQ-029 During reset all outputs SHALL be 0: gnt*, done*, err, result, flags, alu_* ports.
REQ-030 last_grant SHALL reset to 1, so requester 0 wins the first tie.

Configuration
REQ-031 Macro ALU_ARB_TIMEOUT_EN defined: WAIT counter counts from 0; reaching TIMEOUT without alu_result_ready -> DONE with result=8'h00, flags=5'b0, err=1 alongside done.
REQ-032 Macro ALU_ARB_TIMEOUT_EN undefined: no counter, WAIT waits indefinitely, err tied 0.

Verification
REQ-033 Only req0, opcode0=5'd0, a0=8'h12, b0=8'h34; ALU model returns 8'h46 after 3 cycles -> gnt0 high 6 cycles, done0 one pulse, result=8'h46, gnt1 never high.
REQ-034 req0 and req1 asserted together, held for 4 operations -> grant order 0,1,0,1; done0/done1 alternate.
REQ-035 req1 dropped one cycle after ISSUE -> operation completes, done1 pulses, result captured.
REQ-036 rst low during WAIT -> same cycle gnt*, alu_enable, alu_input_ready low; no done; after release, req0+req1 together -> requester 0 granted first.
REQ-037 Macro defined, TIMEOUT=16, ALU model never raises result_ready -> after 16 WAIT cycles done0 and err pulse together, result=8'h00; macro undefined -> FSM stays in WAIT, err stays 0.
REQ-038 ALU model asserts alu_result_ready in IDLE -> ignored, result unchanged, no done.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter that lets two requesters share one
// multi-cycle ALU. A granted operation is issued for one cycle, then the
// arbiter waits for the ALU's result_ready, captures result/flags and
// pulses done to the owning requester.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   req0/1, opcode0/1        request and opcode per requester
//   a0/b0/a1/b1, cin*/bin*   operands and carry/borrow in per requester
//   gnt0/1, done0/1          ownership and one-cycle completion pulse
//   result, flags            captured {overflow,negative,zero,carry,borrow}
//   err                      one-cycle timeout pulse, coincident with done
//   alu_*                    outputs to / inputs from the shared ALU
//
// Build option: define ALU_ARB_TIMEOUT_EN to abort a WAIT lasting TIMEOUT
// cycles (result/flags forced to zero, err pulsed). Without it the arbiter
// waits for the ALU indefinitely and err is tied low.
//
// state | meaning
// IDLE  | no operation; arbitrate and latch winner when any req is high
// ISSUE | operands presented, alu_input_ready high for this one cycle
// WAIT  | ALU busy; leave on alu_result_ready (or timeout when enabled)
// DONE  | result captured, done pulse to the owner
module alu_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [4:0] opcode0,
  input  logic [4:0] opcode1,
  input  logic [7:0] a0,
  input  logic [7:0] b0,
  input  logic [7:0] a1,
  input  logic [7:0] b1,
  input  logic       cin0,
  input  logic       bin0,
  input  logic       cin1,
  input  logic       bin1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic [7:0] result,
  output logic [4:0] flags,
  output logic       err,
  output logic [4:0] alu_opcode,
  output logic [7:0] alu_operand_A,
  output logic [7:0] alu_operand_B,
  output logic       alu_carry_in,
  output logic       alu_borrow_in,
  output logic       alu_enable,
  output logic       alu_input_ready,
  input  logic [7:0] alu_result_out,
  input  logic       alu_result_ready,
  input  logic       alu_carry_out,
  input  logic       alu_borrow_out,
  input  logic       alu_zero,
  input  logic       alu_negative,
  input  logic       alu_overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;
  logic   last_grant;
  logic   any_req;
  logic   winner;
  logic   wait_expired;

  assign any_req = req0 | req1;
  // On a tie the requester that did not own the ALU last time wins.
  assign winner  = (req0 & req1) ? ~last_grant : req1;

`ifdef ALU_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             timed_out;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt  <= '0;
      timed_out <= 1'b0;
    end else begin
      if (state == ISSUE) wait_cnt <= '0;
      else if (state == WAIT) wait_cnt <= wait_cnt + 1'b1;
      // Remember why WAIT was left so err can accompany the done pulse.
      if (state == WAIT) timed_out <= wait_expired;
    end
  end

  // The counter value equals the number of WAIT cycles already completed.
  assign wait_expired = (state == WAIT) && !alu_result_ready && (wait_cnt == CNT_LAST);
  assign err          = (state == DONE) && timed_out;
`else
  // TIMEOUT has no effect without the counter.
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign wait_expired   = 1'b0;
  assign err            = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (alu_result_ready || wait_expired) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt0            = 1'b0;
    gnt1            = 1'b0;
    done0           = 1'b0;
    done1           = 1'b0;
    alu_enable      = 1'b0;
    alu_input_ready = 1'b0;
    case (state)
      ISSUE: begin
        gnt0            = ~last_grant;
        gnt1            = last_grant;
        alu_enable      = 1'b1;
        alu_input_ready = 1'b1;
      end
      WAIT: begin
        gnt0       = ~last_grant;
        gnt1       = last_grant;
        alu_enable = 1'b1;
      end
      DONE: begin
        gnt0  = ~last_grant;
        gnt1  = last_grant;
        done0 = ~last_grant;
        done1 = last_grant;
      end
      default: ;
    endcase
  end

  // Operand ports are loaded on the IDLE->ISSUE edge and then left alone,
  // so they stay stable for the whole operation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant    <= 1'b1;
      alu_opcode    <= '0;
      alu_operand_A <= '0;
      alu_operand_B <= '0;
      alu_carry_in  <= 1'b0;
      alu_borrow_in <= 1'b0;
      result        <= '0;
      flags         <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        last_grant <= winner;
        if (winner) begin
          alu_opcode    <= opcode1;
          alu_operand_A <= a1;
          alu_operand_B <= b1;
          alu_carry_in  <= cin1;
          alu_borrow_in <= bin1;
        end else begin
          alu_opcode    <= opcode0;
          alu_operand_A <= a0;
          alu_operand_B <= b0;
          alu_carry_in  <= cin0;
          alu_borrow_in <= bin0;
        end
      end
      if (state == WAIT && alu_result_ready) begin
        result <= alu_result_out;
        flags  <= {alu_overflow, alu_negative, alu_zero, alu_carry_out, alu_borrow_out};
      end else if (wait_expired) begin
        result <= '0;
        flags  <= '0;
      end
    end
  end

endmodule
